// File: rtl/two_ch_test_wave_gen.sv
// rtl/two_ch_test_wave_gen.sv - two-channel programmable square-wave source (optional TWG_PERIOD_ECHO_EN adds active-period outputs)
module two_ch_test_wave_gen #(
    parameter int DW         = 14,
    parameter int PW         = 32,
    parameter int AMPLITUDE  = 4096,
    parameter int MIN_PERIOD = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [PW-1:0] period_in_A,
    input  logic          load_A,
    input  logic [PW-1:0] period_in_B,
    input  logic          load_B,
    output logic [DW-1:0] signal_out_A,
    output logic [DW-1:0] signal_out_B,
    output logic          pend_A,
    output logic          pend_B
`ifdef TWG_PERIOD_ECHO_EN
    ,
    output logic [PW-1:0] active_period_A,
    output logic [PW-1:0] active_period_B
`endif
);

    localparam logic [DW-1:0] HI_LEVEL = DW'(AMPLITUDE);
    localparam logic [DW-1:0] LO_LEVEL = DW'(-AMPLITUDE);
    localparam logic [PW-1:0] MIN_P    = PW'(MIN_PERIOD);

    typedef enum logic {IDLE, RUN} state_t;

    logic          load_v [2];
    logic [PW-1:0] period_v [2];

    assign load_v[0]   = load_A;
    assign load_v[1]   = load_B;
    assign period_v[0] = period_in_A;
    assign period_v[1] = period_in_B;

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        state_t        state;
        logic [PW-1:0] active;
        logic [PW-1:0] pending;
        logic [PW-1:0] cnt;
        logic          pend;
        logic [DW-1:0] sig;
        logic          boundary;

        // Last cycle of the current period; the only point a pending word may take over while running.
        assign boundary = (cnt == active - PW'(1));

        // Per-channel sequencer: load capture, period apply, counting and waveform register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state   <= IDLE;
                active  <= '0;
                pending <= '0;
                cnt     <= '0;
                pend    <= 1'b0;
                sig     <= '0;
            end else begin
                if (state == IDLE) begin
                    sig <= '0;
                    cnt <= '0;
                    if (pend) begin
                        active <= pending;
                        pend   <= 1'b0;
                    end
                    // Start decision uses the period already in use, not one being applied this edge.
                    if (enable && (active >= MIN_P)) begin
                        state <= RUN;
                    end
                end else begin
                    sig <= (cnt < (active >> 1)) ? HI_LEVEL : LO_LEVEL;
                    if (!enable) begin
                        // Abandon the period; any pending word survives for later.
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (boundary) begin
                        cnt <= '0;
                        if (pend) begin
                            active <= pending;
                            pend   <= 1'b0;
                            if (pending < MIN_P) begin
                                state <= IDLE;
                            end
                        end
                    end else begin
                        cnt <= cnt + PW'(1);
                    end
                end
                // A load always wins over the clear above so it is never lost.
                if (load_v[ch]) begin
                    pending <= period_v[ch];
                    pend    <= 1'b1;
                end
            end
        end
    end

    assign signal_out_A = g_ch[0].sig;
    assign signal_out_B = g_ch[1].sig;
    assign pend_A       = g_ch[0].pend;
    assign pend_B       = g_ch[1].pend;

`ifdef TWG_PERIOD_ECHO_EN
    assign active_period_A = g_ch[0].active;
    assign active_period_B = g_ch[1].active;
`endif

endmodule
